// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width
// and the controller state encoding.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_fs_cell.sv
// One-bit combinational full-subtract cell. It forms a - b - bin for a single
// bit position and produces the difference bit plus the borrow to the next bit.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out for one bit position
    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtract cell. The result, borrow-out and signed
// overflow are published together when the operation completes and are held
// until the next completion or reset.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] acc_shift;

    // The single subtract cell always works on the current LSBs and running borrow
    fs_cell u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .bin (br_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // Difference bits enter from the MSB side so the LSB ends up at bit 0
    assign acc_shift = (acc_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    assign ready = (state_q == ST_IDLE);
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

    // Next-state and datapath updates; everything holds unless the state acts on it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = cell_bo;
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    diff_d  = acc_shift;
                    bout_d  = cell_bo;
                    ovf_d   = cell_bo ^ br_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that abandons any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH 8, 13 and 1. Expected results are
// queued when an operation is launched and compared when done is observed.
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        bin8 = 1'b0;
    logic        ready8, busy8, done8, bout8, ovf8;
    logic [7:0]  diff8;

    logic        start13 = 1'b0;
    logic [12:0] a13 = '0;
    logic [12:0] b13 = '0;
    logic        bin13 = 1'b0;
    logic        ready13, busy13, done13, bout13, ovf13;
    logic [12:0] diff13;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0;
    logic [0:0]  b1 = '0;
    logic        bin1 = 1'b0;
    logic        ready1, busy1, done1, bout1, ovf1;
    logic [0:0]  diff1;

    typedef struct {
        int          lane;
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    logic        doneL[3];
    logic        readyL[3];
    logic [63:0] diffL[3];
    logic        boutL[3];
    logic        ovfL[3];

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_sub #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
        .ready(ready13), .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .ovf(ovf13)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    assign doneL[0]  = done8;
    assign doneL[1]  = done13;
    assign doneL[2]  = done1;
    assign readyL[0] = ready8;
    assign readyL[1] = ready13;
    assign readyL[2] = ready1;
    assign diffL[0]  = 64'(diff8);
    assign diffL[1]  = 64'(diff13);
    assign diffL[2]  = 64'(diff1);
    assign boutL[0]  = bout8;
    assign boutL[1]  = bout13;
    assign boutL[2]  = bout1;
    assign ovfL[0]   = ovf8;
    assign ovfL[1]   = ovf13;
    assign ovfL[2]   = ovf1;

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle index used to measure accept-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int laneWidth(int lane);
        case (lane)
            0:       return 8;
            1:       return 13;
            default: return 1;
        endcase
    endfunction

    // Arithmetic reference: returns {ovf, bout, diff}
    function automatic logic [65:0] refModel(int w, logic [63:0] av, logic [63:0] bv, logic bi);
        logic [63:0] mask;
        logic [64:0] t;
        logic [63:0] d;
        logic        bo;
        logic        ov;
        longint      sa, sb, s, hi, lo;
        mask = (64'd1 << w) - 64'd1;
        t    = {1'b0, av & mask} - {1'b0, bv & mask} - 65'(bi);
        d    = t[63:0] & mask;
        bo   = t[w];
        sa   = longint'(av & mask);
        sb   = longint'(bv & mask);
        if (av[w-1]) sa = sa - (longint'(1) << w);
        if (bv[w-1]) sb = sb - (longint'(1) << w);
        s    = sa - sb - longint'(bi);
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        ov   = (s > hi) || (s < lo);
        return {ov, bo, d};
    endfunction

    task automatic setInputs(int lane, logic st, logic [63:0] av, logic [63:0] bv, logic bi);
        case (lane)
            0: begin start8  = st; a8  = av[7:0];  b8  = bv[7:0];  bin8  = bi; end
            1: begin start13 = st; a13 = av[12:0]; b13 = bv[12:0]; bin13 = bi; end
            default: begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi; end
        endcase
    endtask

    task automatic pushExp(int lane, logic [63:0] d, logic bo, logic ov);
        exp_t e;
        e.lane = lane;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.acc  = cyc;
        sbq.push_back(e);
    endtask

    // Launch one operation from an IDLE cycle and wait until the lane is idle again
    task automatic driveOp(int lane, logic [63:0] av, logic [63:0] bv, logic bi,
                           logic [63:0] ed, logic ebo, logic eov);
        int w;
        w = laneWidth(lane);
        setInputs(lane, 1'b1, av, bv, bi);
        pushExp(lane, ed, ebo, eov);
        @(posedge clk); #1;
        setInputs(lane, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        repeat (w + 2) @(posedge clk);
        #1;
    endtask

    task automatic modelOp(int lane, logic [63:0] av, logic [63:0] bv, logic bi);
        logic [65:0] r;
        r = refModel(laneWidth(lane), av, bv, bi);
        driveOp(lane, av, bv, bi, r[63:0], r[64], r[65]);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        for (int l = 0; l < 3; l++) begin
            if (doneL[l] === 1'b1) begin
                nChecks++;
                if (sbq.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL spurious_done lane %0d: got done=1, expected no pending result", l);
                end else begin
                    e = sbq.pop_front();
                    nChecks++;
                    if (e.lane !== l) begin
                        nFails++;
                        $display("[TB] FAIL done_lane: got lane %0d, expected lane %0d", l, e.lane);
                    end
                    nChecks++;
                    if (diffL[l] !== e.diff) begin
                        nFails++;
                        $display("[TB] FAIL diff lane %0d: got %h, expected %h", l, diffL[l], e.diff);
                    end
                    nChecks++;
                    if (boutL[l] !== e.bout) begin
                        nFails++;
                        $display("[TB] FAIL bout lane %0d: got %b, expected %b", l, boutL[l], e.bout);
                    end
                    nChecks++;
                    if (ovfL[l] !== e.ovf) begin
                        nFails++;
                        $display("[TB] FAIL ovf lane %0d: got %b, expected %b", l, ovfL[l], e.ovf);
                    end
                    nChecks++;
                    if ((cyc - e.acc) !== (laneWidth(l) + 1)) begin
                        nFails++;
                        $display("[TB] FAIL latency lane %0d: got %0d cycles, expected %0d", l, cyc - e.acc, laneWidth(l) + 1);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int l = 0; l < 3; l++) setInputs(l, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nChecks++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl8: got ready/busy/done=%b, expected 100", {ready8, busy8, done8});
        end
        nChecks++;
        if ({diff8, bout8, ovf8} !== 10'd0) begin
            nFails++;
            $display("[TB] FAIL reset_result8: got diff=%h bout=%b ovf=%b, expected all zero", diff8, bout8, ovf8);
        end
        nChecks++;
        if ({ready13, busy13, done13, diff13, bout13, ovf13} !== {3'b100, 15'd0}) begin
            nFails++;
            $display("[TB] FAIL reset_w13: got r/b/d=%b diff=%h, expected 100 and zero", {ready13, busy13, done13}, diff13);
        end
        nChecks++;
        if ({ready1, busy1, done1, diff1, bout1, ovf1} !== 6'b100000) begin
            nFails++;
            $display("[TB] FAIL reset_w1: got %b, expected 100000", {ready1, busy1, done1, diff1, bout1, ovf1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed_w8();
        driveOp(0, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, 1'b0);
        driveOp(0, 64'h00, 64'h01, 1'b0, 64'hFF, 1'b1, 1'b0);
        driveOp(0, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1);
        driveOp(0, 64'h00, 64'h00, 1'b1, 64'hFF, 1'b1, 1'b0);
        driveOp(0, 64'h7F, 64'hFF, 1'b0, 64'h80, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        nChecks++;
        if ({ready8, diff8, bout8, ovf8} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL hold_result: got ready=%b diff=%h bout=%b ovf=%b, expected 1 80 1 1", ready8, diff8, bout8, ovf8);
        end
    endtask

    task automatic test_ignore_start();
        setInputs(0, 1'b1, 64'h10, 64'h01, 1'b0);
        pushExp(0, 64'h0F, 1'b0, 1'b0);
        @(posedge clk); #1;
        setInputs(0, 1'b0, 64'h10, 64'h01, 1'b0);
        @(posedge clk); #1;
        setInputs(0, 1'b1, 64'hAA, 64'h55, 1'b1);
        nChecks++;
        if ({ready8, busy8} !== 2'b01) begin
            nFails++;
            $display("[TB] FAIL busy_run2: got ready/busy=%b, expected 01", {ready8, busy8});
        end
        @(posedge clk); #1;
        setInputs(0, 1'b0, 64'h3C, 64'hC3, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        nChecks++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL idle_after_ignored: got r/b/d=%b, expected 100", {ready8, busy8, done8});
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        setInputs(0, 1'b1, 64'h33, 64'h11, 1'b0);
        @(posedge clk); #1;
        setInputs(0, 1'b0, 64'h00, 64'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (busy8 !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL busy_run4: got busy=%b, expected 1", busy8);
        end
        rst = 1'b1;
        setInputs(0, 1'b1, 64'h44, 64'h01, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        setInputs(0, 1'b0, 64'h00, 64'h00, 1'b0);
        nChecks++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL reset_midrun_ctrl: got r/b/d=%b, expected 100", {ready8, busy8, done8});
        end
        nChecks++;
        if ({diff8, bout8, ovf8} !== 10'd0) begin
            nFails++;
            $display("[TB] FAIL reset_midrun_result: got diff=%h bout=%b ovf=%b, expected zero", diff8, bout8, ovf8);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_width1();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            modelOp(2, 64'(v[2]), 64'(v[1]), v[0]);
        end
    endtask

    task automatic test_back_to_back(int lane, int nOps);
        int          w;
        logic [63:0] mask, av, bv;
        logic        bi;
        logic [65:0] r;
        w    = laneWidth(lane);
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < nOps; i++) begin
            av = {$urandom, $urandom} & mask;
            bv = {$urandom, $urandom} & mask;
            bi = 1'($urandom_range(1, 0));
            r  = refModel(w, av, bv, bi);
            if (i > 0) begin
                nChecks++;
                if (readyL[lane] !== 1'b1) begin
                    nFails++;
                    $display("[TB] FAIL b2b_idle lane %0d op %0d: got ready=%b, expected 1", lane, i, readyL[lane]);
                end
            end
            setInputs(lane, 1'b1, av, bv, bi);
            pushExp(lane, r[63:0], r[64], r[65]);
            @(posedge clk); #1;
            setInputs(lane, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            repeat (w) @(posedge clk);
            #1;
            nChecks++;
            if (readyL[lane] !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL b2b_done_not_ready lane %0d op %0d: got ready=%b, expected 0", lane, i, readyL[lane]);
            end
            setInputs(lane, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            @(posedge clk); #1;
        end
        setInputs(lane, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (w + 3) @(posedge clk);
        #1;
    endtask

    // Test sequence
    initial begin
        $display("[TB] starting serial_sub bench");
        test_reset();
        test_directed_w8();
        test_ignore_start();
        test_reset_mid_run();
        test_width1();
        test_back_to_back(0, 20);
        test_back_to_back(1, 20);
        test_back_to_back(2, 10);
        nChecks++;
        if (sbq.size() !== 0) begin
            nFails++;
            $display("[TB] FAIL pending_results: got %0d results outstanding, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
